// File: rtl/instr_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// The encoder takes the slave view; the producer/consumer side takes master.
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_fmt;
   logic [6:0]  in_opcode;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_addr;

   modport master (
      output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
      output in_rd, in_rs1, in_rs2, in_imm, out_ready,
      input  in_ready, out_valid, out_instr, out_addr
   );

   modport slave (
      input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
      input  in_rd, in_rs1, in_rs2, in_imm, out_ready,
      output in_ready, out_valid, out_instr, out_addr
   );
endinterface

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: packs decoded fields into words, queues them
// with sequential addresses. Optional macro IMM_RANGE_CHECK_EN.
module instr_encoder #(
   parameter int          DEPTH     = 2,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   instr_encoder_if.slave bus,
   output logic           err
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [31:0] NOP      = 32'h0000_0013;

   localparam logic [2:0] F_I = 3'b000;
   localparam logic [2:0] F_S = 3'b001;
   localparam logic [2:0] F_B = 3'b010;
   localparam logic [2:0] F_U = 3'b011;
   localparam logic [2:0] F_J = 3'b100;
   localparam logic [2:0] F_R = 3'b101;

   logic [31:0]   mem_instr [DEPTH];
   logic [31:0]   mem_addr  [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [31:0]   pc;

   logic        full, empty, push, pop;
   logic        fmt_bad, align_bad, range_bad, bad;
   logic [31:0] enc, word, imm;

   assign imm = bus.in_imm;

   always_comb begin
      enc     = '0;
      fmt_bad = 1'b0;
      unique case (1'b1)
         (bus.in_fmt == F_R): enc = {bus.in_funct7, bus.in_rs2, bus.in_rs1,
                                     bus.in_funct3, bus.in_rd, bus.in_opcode};
         (bus.in_fmt == F_I): enc = {imm[11:0], bus.in_rs1, bus.in_funct3,
                                     bus.in_rd, bus.in_opcode};
         (bus.in_fmt == F_S): enc = {imm[11:5], bus.in_rs2, bus.in_rs1,
                                     bus.in_funct3, imm[4:0], bus.in_opcode};
         (bus.in_fmt == F_B): enc = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1,
                                     bus.in_funct3, imm[4:1], imm[11],
                                     bus.in_opcode};
         (bus.in_fmt == F_U): enc = {imm[31:12], bus.in_rd, bus.in_opcode};
         (bus.in_fmt == F_J): enc = {imm[20], imm[10:1], imm[11], imm[19:12],
                                     bus.in_rd, bus.in_opcode};
         default:             fmt_bad = 1'b1;
      endcase
   end

   assign align_bad = ((bus.in_fmt == F_B) || (bus.in_fmt == F_J)) && imm[0];

`ifdef IMM_RANGE_CHECK_EN
   // Signed fit: all bits above the field's sign bit must equal it.
   always_comb begin
      range_bad = 1'b0;
      unique case (1'b1)
         (bus.in_fmt == F_I),
         (bus.in_fmt == F_S): range_bad = !((&imm[31:11]) || !(|imm[31:11]));
         (bus.in_fmt == F_B): range_bad = !((&imm[31:12]) || !(|imm[31:12]));
         (bus.in_fmt == F_J): range_bad = !((&imm[31:20]) || !(|imm[31:20]));
         (bus.in_fmt == F_U): range_bad = |imm[11:0];
         default:             range_bad = 1'b0;
      endcase
   end
`else
   assign range_bad = 1'b0;
`endif

   assign bad  = fmt_bad | align_bad | range_bad;
   assign word = bad ? NOP : enc;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   assign bus.in_ready  = !full && !clr;
   assign bus.out_valid = !empty && !clr;
   assign bus.out_instr = mem_instr[rd_ptr];
   assign bus.out_addr  = mem_addr[rd_ptr];

   assign push = bus.in_valid && bus.in_ready;
   assign pop  = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_instr[i] <= '0;
            mem_addr[i]  <= BASE_ADDR;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         pc     <= BASE_ADDR;
         err    <= 1'b0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         pc     <= BASE_ADDR;
         err    <= 1'b0;
      end else begin
         if (push) begin
            mem_instr[wr_ptr] <= word;
            mem_addr[wr_ptr]  <= pc;
            wr_ptr            <= wr_ptr + AW'(1);
            pc                <= pc + 32'd4;
            if (bad) err <= 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop) count <= count + (AW+1)'(1);
         else if (!push && pop) count <= count - (AW+1)'(1);
      end
   end

endmodule
